s9_display_driver: RTL and testbench
====================================

// Module: s9_display_driver
// PURPOSE
//   Downstream stage of the calculator datapath (Enter/DataIn -> ToDisplay/Flags/Status).
//   Takes the 16-bit result word and the 3-bit Status code and drives a multiplexed
//   8-digit active-low 7-segment display.
//   Hex mode shows 4 hex digits. Decimal mode shows up to 5 BCD digits, produced by a
//   sequential double-dabble converter with leading-zero blanking.
//   Digit 7 always shows Status as a numeral 0-7.
// PARAMETERS
//   DIGIT_CYCLES  100000  clk cycles each digit stays lit (1 ms @100 MHz); bench uses 4
// PORTS
//   clk       in   1   system clock, all logic on rising edge
//   reset     in   1   asynchronous, active-high reset
//   value     in   16  result word to display (unsigned)
//   status    in   3   FSM status code of the upstream stage
//   dec_mode  in   1   1 = decimal (BCD) display, 0 = hex display
//   anodes    out  8   digit enables, active-low, one-hot or all-high
//   segments  out  7   {g,f,e,d,c,b,a}, active-low
//   dp        out  1   decimal point, active-low
//   busy      out  1   1 while a BCD conversion is in progress
// BEHAVIOUR
//   Reset values: anodes=8'hFF, segments=7'h7F, dp=1, busy=0.
//   Reset state: snapshot=0, digit index=0, refresh count=0, FSM=IDLE, last-converted pair=invalid.
//   Input capture: value/dec_mode/status registered every cycle (1-cycle delay).
//   FSM IDLE/SHIFT/DONE:
//     IDLE: if captured {value,dec_mode} != last converted pair:
//       dec_mode=1 -> load shift reg {20'b0,value}, count=0, -> SHIFT.
//       dec_mode=0 -> -> DONE, snapshot nibbles = value nibbles.
//     SHIFT: per cycle, add 3 to each BCD nibble >=5, then shift left 1.
//       After 16 shifts -> DONE. busy=1 only in SHIFT.
//     DONE: write 20-bit BCD (or hex) to snapshot, record converted pair, -> IDLE.
//   Latency from input edge to snapshot update: hex <=3 cycles; decimal <=19 cycles.
//   Display reads only the snapshot, so no partial/torn values are ever shown.
//   Input change during SHIFT: ignored until IDLE, then reconverted. The old value
//     completes first and is shown briefly.
//   Refresh:
//     Counter 0..DIGIT_CYCLES-1. On wrap, digit index increments modulo 8 (7 -> 0).
//     anodes[i]=0 only for the current index and only if digit i is not blank.
//   Digit map, hex mode:
//     digits 0-3 = value nibbles (LS first), digits 4-6 blank.
//   Digit map, decimal mode:
//     digits 0-4 = BCD (LS first), digits 5-6 blank.
//     Leading zeros in digits 1-4 blank; digit 0 always lit (value 0 shows "0").
//   Digit 7: status, zero-extended, shown as 0-7.
//   dp: low only on digit 0 in hex mode (hex indicator); else 1.
//   segments: driven from the encoding of the current digit.
//     7'h7F when the current digit is blank.
//   Reset mid-conversion: immediate return to reset values.
//     After release, the current input converts normally.
// STRUCTURE
//   Package s9_display_pkg:
//     state_t enum {IDLE,SHIFT,DONE}
//     NUM_DIGITS=8, BCD_DIGITS=5
//     function hex_to_seg(4b)->7b active-low, with 0..F table.
//   Sub-module s9_bin2bcd_seq: start/value in, bcd[19:0]/done/busy out.
//     Holds the SHIFT loop. Parent holds the refresh counter, snapshot and digit mux.
// TESTING (DIGIT_CYCLES=4)
//   1. reset=1 for 3 cycles -> anodes=8'hFF, segments=7'h7F, dp=1, busy=0.
//   2. dec_mode=0, value=16'hBEEF -> within 3 cycles, digit0 segments=7'b0001110 (F),
//      digit3 shows B, dp=0 on digit0, anodes[6:4] never low.
//   3. dec_mode=1, value=16'hFFFF -> busy high 16 cycles -> digits 4..0 = 6,5,5,3,5.
//   4. dec_mode=1, value=42 -> only anodes[0], anodes[1], anodes[7] ever go low;
//      digit1=4, digit0=2.
//   5. value=1000 then 12345 three cycles later -> final digits 1,2,3,4,5 within 38 cycles;
//      busy=0 afterwards.
//   6. status=5 -> digit7 segments=7'b0010010. reset pulse mid-SHIFT -> reset values at once,
//      then current value displayed within 19 cycles.

Source files
------------

// File: rtl/s9_display_pkg.sv
// Shared types and helpers for the s9 display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package s9_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_DIGITS = 5;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/s9_bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits,
// one shift per cycle, 16 cycles per conversion.
module s9_bin2bcd_seq
  import s9_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  output logic [19:0] bcd,
  output logic        done,
  output logic        busy
);

  logic [35:0] sr;
  logic [35:0] sr_adj;
  logic [3:0]  cnt;
  logic        run;

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sr[16+4*i +: 4] >= 4'd5)
        sr_adj[16+4*i +: 4] = sr[16+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start && !run) begin
      sr  <= {20'b0, value};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sr  <= {sr_adj[34:0], 1'b0};
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15)
        run <= 1'b0;
    end
  end

  // done flags the final shift; bcd is settled on the following cycle
  assign done = run && (cnt == 4'd15);
  assign busy = run;
  assign bcd  = sr[35:16];

endmodule

// File: rtl/s9_display_driver.sv
// Multiplexed 8-digit 7-segment driver: hex or blanked BCD view of
// the result word, with the status code on digit 7.
module s9_display_driver
  import s9_display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [2:0]  status,
  input  logic        dec_mode,
  output logic [7:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        busy
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIGIT_CYCLES - 1);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [15:0]   cap_value;
  logic [2:0]    cap_status;
  logic          cap_dec;
  state_t        state, state_nx;
  logic          start;
  logic          differs;
  logic [15:0]   pend_value;
  logic          pend_dec;
  logic [15:0]   last_value;
  logic          last_dec;
  logic          last_valid;
  logic [19:0]   snap;
  logic          snap_dec;
  logic [CW-1:0] rcnt;
  logic [IW-1:0] idx;
  logic [3:0]    nib;
  logic          blank;
  logic [19:0]   conv_bcd;
  logic          conv_done;
  logic          conv_busy;

  s9_bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (cap_value),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .busy  (conv_busy)
  );

  assign differs = !last_valid ||
                   ({cap_value, cap_dec} != {last_value, last_dec});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (differs) begin
          if (cap_dec) begin
            start    = 1'b1;
            state_nx = SHIFT;
          end else begin
            state_nx = DONE;
          end
        end
      end
      SHIFT:   if (conv_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // pend holds the pair being converted so later input edits cannot tear it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_value  <= '0;
      cap_status <= '0;
      cap_dec    <= 1'b0;
      pend_value <= '0;
      pend_dec   <= 1'b0;
      last_value <= '0;
      last_dec   <= 1'b0;
      last_valid <= 1'b0;
      snap       <= '0;
      snap_dec   <= 1'b0;
    end else begin
      cap_value  <= value;
      cap_status <= status;
      cap_dec    <= dec_mode;
      if (state == IDLE && differs) begin
        pend_value <= cap_value;
        pend_dec   <= cap_dec;
      end
      if (state == DONE) begin
        snap       <= pend_dec ? conv_bcd : {4'b0, pend_value};
        snap_dec   <= pend_dec;
        last_value <= pend_value;
        last_dec   <= pend_dec;
        last_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == CMAX) begin
      rcnt <= '0;
      idx  <= idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b1;
    unique case (idx)
      3'd0: begin
        nib   = snap[3:0];
        blank = 1'b0;
      end
      3'd1: begin
        nib   = snap[7:4];
        blank = snap_dec && !(|snap[19:4]);
      end
      3'd2: begin
        nib   = snap[11:8];
        blank = snap_dec && !(|snap[19:8]);
      end
      3'd3: begin
        nib   = snap[15:12];
        blank = snap_dec && !(|snap[19:12]);
      end
      3'd4: begin
        nib   = snap[19:16];
        blank = !snap_dec || !(|snap[19:16]);
      end
      3'd7: begin
        nib   = {1'b0, cap_status};
        blank = 1'b0;
      end
      default: begin
        nib   = 4'h0;
        blank = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes   <= 8'hFF;
      segments <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      anodes   <= blank ? 8'hFF : ~(8'd1 << idx);
      segments <= blank ? 7'h7F : hex_to_seg(nib);
      dp       <= !((idx == '0) && !snap_dec);
    end
  end

  assign busy = conv_busy;

endmodule

// File: tb/tb_s9_display_driver.sv
// Directed bench for s9_display_driver with a 4-cycle digit period.
// Frames are scanned and each lit digit's pattern is checked.
module tb_s9_display_driver;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [2:0]  status;
  logic        dec_mode;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        busy;

  int total;
  int bad;

  logic [6:0] seg_of [8];
  logic       dp_of  [8];
  logic [7:0] seen;
  logic       shape_ok;
  logic       blank_ok;
  int         busy_cnt;

  s9_display_driver #(.DIGIT_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .status   (status),
    .dec_mode (dec_mode),
    .anodes   (anodes),
    .segments (segments),
    .dp       (dp),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // records the first pattern seen under each anode over a full frame
  task automatic scan();
    logic [7:0] oh;
    seen     = 8'h00;
    shape_ok = 1'b1;
    blank_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      seg_of[i] = 7'h7F;
      dp_of[i]  = 1'b1;
    end
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      seen = seen | ~anodes;
      if (anodes == 8'hFF) begin
        if (segments !== 7'h7F) blank_ok = 1'b0;
      end else begin
        oh = ~anodes;
        if ((oh & (oh - 8'd1)) != 8'h00) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (oh == (8'd1 << i) && seg_of[i] == 7'h7F && dp_of[i]) begin
            seg_of[i] = segments;
            dp_of[i]  = dp;
          end
        end
      end
    end
    chk("anode_onehot", {31'b0, shape_ok}, 32'd1);
    chk("blank_segs", {31'b0, blank_ok}, 32'd1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    value    = 16'h0000;
    status   = 3'd0;
    dec_mode = 1'b0;

    cycles(3);
    chk("rst_anodes", {24'b0, anodes}, 32'hFF);
    chk("rst_segments", {25'b0, segments}, 32'h7F);
    chk("rst_dp", {31'b0, dp}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    reset    = 1'b0;
    value    = 16'hBEEF;
    dec_mode = 1'b0;
    cycles(4);
    scan();
    chk("hex_d0", {25'b0, seg_of[0]}, 32'h0E);
    chk("hex_d1", {25'b0, seg_of[1]}, 32'h06);
    chk("hex_d2", {25'b0, seg_of[2]}, 32'h06);
    chk("hex_d3", {25'b0, seg_of[3]}, 32'h03);
    chk("hex_dp0", {31'b0, dp_of[0]}, 32'd0);
    chk("hex_dp3", {31'b0, dp_of[3]}, 32'd1);
    chk("hex_seen", {24'b0, seen}, 32'h8F);
    chk("hex_d7", {25'b0, seg_of[7]}, 32'h40);

    value    = 16'hFFFF;
    dec_mode = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("ffff_busy_cycles", busy_cnt, 32'd16);
    scan();
    chk("ffff_d4", {25'b0, seg_of[4]}, 32'h02);
    chk("ffff_d3", {25'b0, seg_of[3]}, 32'h12);
    chk("ffff_d2", {25'b0, seg_of[2]}, 32'h12);
    chk("ffff_d1", {25'b0, seg_of[1]}, 32'h30);
    chk("ffff_d0", {25'b0, seg_of[0]}, 32'h12);
    chk("ffff_dp0", {31'b0, dp_of[0]}, 32'd1);
    chk("ffff_seen", {24'b0, seen}, 32'h9F);

    value = 16'd42;
    cycles(25);
    scan();
    chk("d42_seen", {24'b0, seen}, 32'h83);
    chk("d42_d1", {25'b0, seg_of[1]}, 32'h19);
    chk("d42_d0", {25'b0, seg_of[0]}, 32'h24);

    value = 16'd1000;
    cycles(3);
    value = 16'd12345;
    cycles(35);
    chk("reconv_busy", {31'b0, busy}, 32'd0);
    scan();
    chk("d12345_d4", {25'b0, seg_of[4]}, 32'h79);
    chk("d12345_d3", {25'b0, seg_of[3]}, 32'h24);
    chk("d12345_d2", {25'b0, seg_of[2]}, 32'h30);
    chk("d12345_d1", {25'b0, seg_of[1]}, 32'h19);
    chk("d12345_d0", {25'b0, seg_of[0]}, 32'h12);
    chk("d12345_busy", {31'b0, busy}, 32'd0);

    status = 3'd5;
    cycles(2);
    scan();
    chk("status5_d7", {25'b0, seg_of[7]}, 32'h12);

    value = 16'd999;
    cycles(6);
    chk("mid_shift_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_anodes", {24'b0, anodes}, 32'hFF);
    chk("mid_rst_segments", {25'b0, segments}, 32'h7F);
    chk("mid_rst_dp", {31'b0, dp}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycles(20);
    scan();
    chk("d999_d2", {25'b0, seg_of[2]}, 32'h10);
    chk("d999_d1", {25'b0, seg_of[1]}, 32'h10);
    chk("d999_d0", {25'b0, seg_of[0]}, 32'h10);
    chk("d999_seen", {24'b0, seen}, 32'h87);
    chk("d999_d7", {25'b0, seg_of[7]}, 32'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
